// File: rtl/game_pkg.sv
// Shared types and defaults for the game score controller.
// It holds the FSM state encoding and the score and level widths.
package game_pkg;

    localparam int unsigned SCORE_W        = 7;
    localparam int unsigned LEVEL_W        = 2;
    localparam int unsigned SCORE_MAX_DEF  = 99;
    localparam int unsigned LEVEL_STEP_DEF = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

endpackage

// File: rtl/game_score_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable, and the count holds once it reaches max.
module sat_counter #(
    parameter int unsigned W = 7
) (
    input  logic         slow_clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] max,
    output logic [W-1:0] count
);

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count < max)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/game_score_ctrl.sv
// Game flow FSM with score counter, high-score capture and level decode.
// In PLAY, coincident events resolve as collision over pause over tick.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SCORE_MAX  = SCORE_MAX_DEF,
    parameter int unsigned LEVEL_STEP = LEVEL_STEP_DEF
) (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               collision_i,
    input  logic               tick_i,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         state_o,
    output logic               game_over_o,
    output logic               new_high_o
);

    game_state_t state, state_nxt;
    logic        clear_c;
    logic        enable_c;
    logic        raise_c;

    // State register
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge control strobes
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        enable_c  = 1'b0;
        raise_c   = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start_i) begin
                    state_nxt = ST_PLAY;
                    clear_c   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collision_i) begin
                    state_nxt = ST_OVER;
                    raise_c   = (score > high_score);
                end else if (pause_i) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    enable_c  = tick_i;
                end
            end
            ST_PAUSE: begin
                if (pause_i) begin
                    state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sat_counter #(
        .W (SCORE_W)
    ) u_score (
        .slow_clock (slow_clock),
        .reset      (reset),
        .clear      (clear_c),
        .enable     (enable_c),
        .max        (SCORE_W'(SCORE_MAX)),
        .count      (score)
    );

    // High score is only updated on the PLAY->OVER edge
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            high_score <= '0;
            new_high_o <= 1'b0;
        end else begin
            new_high_o <= raise_c;
            if (raise_c) begin
                high_score <= score;
            end
        end
    end

    // Level thresholds by comparison against multiples of the step
    always_comb begin
        level = 2'd3;
        if (32'(score) < LEVEL_STEP) begin
            level = 2'd0;
        end else if (32'(score) < 2 * LEVEL_STEP) begin
            level = 2'd1;
        end else if (32'(score) < 3 * LEVEL_STEP) begin
            level = 2'd2;
        end
    end

    assign state_o     = state;
    assign game_over_o = (state == ST_OVER);

endmodule

// File: doc/game_score_ctrl.md
GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

Interface
REQ-001 SHALL have parameter SCORE_MAX, default 99, saturation value of score.
REQ-002 SHALL have parameter LEVEL_STEP, default 25, score points per level.
REQ-003 SHALL have port slow_clock  input  1  block clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  synchronous one-cycle pulse: start a new game.
REQ-006 SHALL have port pause_i  input  1  synchronous one-cycle pulse: toggle pause.
REQ-007 SHALL have port collision_i  input  1  synchronous one-cycle pulse: player hit, game ends.
REQ-008 SHALL have port tick_i  input  1  synchronous one-cycle pulse: one score-earning interval elapsed.
REQ-009 SHALL have port score  output  7  current game score, 0..SCORE_MAX.
REQ-010 SHALL have port high_score  output  7  best score since reset.
REQ-011 SHALL have port level  output  2  difficulty level, 0..3.
REQ-012 SHALL have port state_o  output  2  encoded FSM state.
REQ-013 SHALL have port game_over_o  output  1  high while in OVER.
REQ-014 SHALL have port new_high_o  output  1  one-cycle pulse when high_score is raised.

Function
REQ-015 SHALL implement the FSM states IDLE=0, PLAY=1, PAUSE=2, OVER=3, and drive state_o with the current state's code.
REQ-016 SHALL go IDLE->PLAY on start_i, clearing score in the same edge.
REQ-017 SHALL go PLAY->PAUSE on pause_i and PAUSE->PLAY on pause_i.
REQ-018 SHALL go PLAY->OVER on collision_i; collision_i SHALL be ignored in IDLE, PAUSE and OVER.
REQ-019 SHALL go OVER->PLAY on start_i, clearing score in the same edge; start_i SHALL be ignored in PLAY and PAUSE.
REQ-020 SHALL increment score by 1 on tick_i only in PLAY, one cycle after the tick edge, and hold score in all other states.
REQ-021 SHALL saturate score at SCORE_MAX: tick_i at SCORE_MAX leaves score unchanged, with no wrap.
REQ-022 SHALL apply this priority in PLAY when events coincide: collision_i > pause_i > tick_i.
    - Collision with tick: score not incremented, go to OVER.
    - Pause with tick: go to PAUSE, score not incremented.
REQ-023 SHALL, on the PLAY->OVER edge, load high_score with score if score > high_score and assert new_high_o for exactly that one cycle.
REQ-024 SHALL leave high_score unchanged and keep new_high_o at 0 when score <= high_score, equality included.
REQ-025 SHALL derive level combinationally from score:
    - 0 if score < LEVEL_STEP
    - 1 if score < 2*LEVEL_STEP
    - 2 if score < 3*LEVEL_STEP
    - 3 otherwise
    - Thresholds by comparison, no divider.
REQ-026 SHALL drive game_over_o = (state == OVER), decoded from registered state.
REQ-027 SHALL keep score in OVER until the next start_i.

Reset
REQ-028 SHALL, while reset is low, asynchronously force: state IDLE, score 0, high_score 0, new_high_o 0, game_over_o 0, level 0.
REQ-029 SHALL, on reset asserted mid-game (PLAY or PAUSE), discard score and high_score without any high_score update.
REQ-030 SHALL, on the first slow_clock edge after reset deasserts, respond normally to input pulses present at that edge.

Structure
REQ-031 SHALL place the state enum (2-bit) and default constants SCORE_MAX_DEF=99 and LEVEL_STEP_DEF=25 in shared package game_pkg.
REQ-032 SHALL implement score as one sub-module, sat_counter, with ports for clock, reset, clear, enable, max and count; the FSM, high-score register and level decode SHALL remain in game_score_ctrl.

Verification
REQ-033 SHALL cover basic play: reset, start_i, 5 tick_i -> state_o=1, score=5, level=0.
REQ-034 SHALL cover saturation: 120 tick_i in PLAY -> score=99, level=3, no wrap.
REQ-035 SHALL cover pause: pause_i, 3 tick_i, pause_i, 2 tick_i from score=5 -> score=7; state_o=2 during the pause.
REQ-036 SHALL cover high score:
    - collision_i at score=30 -> state_o=3, high_score=30, new_high_o pulses one cycle.
    - Next game, collision_i at score=30 -> no pulse, high_score=30.
REQ-037 SHALL cover simultaneous events: collision_i+tick_i at score=10 -> OVER with score=10; pause_i+tick_i -> PAUSE with score unchanged.
REQ-038 SHALL cover mid-game reset: reset low in PLAY at score=40 -> all outputs 0 and state_o=0 immediately, without waiting for a clock edge.
